// File: rtl/ifid_if.sv
// ifid_if: fetch/decode handshake bundle around the IF/ID queue.
//   Fetch side : in_valid, in_ready, in_pcp4, in_ins
//   Control    : flush (branch redirect), stall (decode back-pressure)
//   Decode side: out_valid, out_pcp4, out_ins, the split instruction fields,
//                im_sext, the format class fmt and the occupancy count.
// slave  = the queue itself; master = the fetch/decode environment.
interface ifid_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pcp4;
    logic [DATA_W-1:0] in_ins;
    logic              flush;
    logic              stall;
    logic              out_valid;
    logic [DATA_W-1:0] out_pcp4;
    logic [DATA_W-1:0] out_ins;
    logic [5:0]        op;
    logic [4:0]        rs_fmt;
    logic [4:0]        rt_ft;
    logic [4:0]        rd_fs;
    logic [4:0]        sh_fd;
    logic [5:0]        fun;
    logic [15:0]       im;
    logic [DATA_W-1:0] im_sext;
    logic [25:0]       ad;
    logic [2:0]        fmt;
    logic [PTR_W:0]    count;

    modport slave (
        input  in_valid, in_pcp4, in_ins, flush, stall,
        output in_ready, out_valid, out_pcp4, out_ins, op, rs_fmt, rt_ft,
               rd_fs, sh_fd, fun, im, im_sext, ad, fmt, count
    );

    modport master (
        output in_valid, in_pcp4, in_ins, flush, stall,
        input  in_ready, out_valid, out_pcp4, out_ins, op, rs_fmt, rt_ft,
               rd_fs, sh_fd, fun, im, im_sext, ad, fmt, count
    );
endinterface

// File: rtl/ifid_queue.sv
// ifid_queue: DEPTH-entry FIFO of {pc+4, instruction} pairs between fetch and
// decode. The head entry is presented already split into MIPS R/I/J/FR/FI
// fields with a format class and a sign-extended immediate.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : ifid_if.slave -- fetch handshake, flush/stall controls,
//                decoded head entry and occupancy count
// When the queue is empty the head is forced to zero so decode sees a NOP.
module ifid_queue #(
    parameter int         DATA_W = 32,
    parameter int         DEPTH  = 4,
    parameter logic [5:0] FP_OP  = 6'b010001
) (
    input  logic  clk,
    input  logic  rst_n,
    ifid_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_J  = 3'd2;
    localparam logic [2:0] FMT_FR = 3'd3;
    localparam logic [2:0] FMT_FI = 3'd4;

    // Format class from opcode; COP1 splits on the fmt field (16/17 = S/D arithmetic).
    function automatic logic [2:0] classify(input logic [5:0] op_v, input logic [4:0] rs_v);
        logic [2:0] f;
        f = FMT_I;
        case (op_v)
            6'd0:       f = FMT_R;
            6'd2, 6'd3: f = FMT_J;
            default: begin
                if (op_v == FP_OP) begin
                    if (rs_v == 5'd16 || rs_v == 5'd17) f = FMT_FR;
                    else                                f = FMT_FI;
                end else begin
                    f = FMT_I;
                end
            end
        endcase
        return f;
    endfunction

    logic [DATA_W-1:0] pcp4_mem_q [DEPTH];
    logic [DATA_W-1:0] ins_mem_q  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q,  count_d;

    logic              valid_s;
    logic              full_s;
    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_ins_s;
    logic [DATA_W-1:0] head_pcp4_s;

    // Handshake qualification; a pop cannot make room for a same-cycle push.
    always_comb begin
        valid_s    = (count_q != (PTR_W+1)'(0));
        full_s     = (count_q == FULL_CNT);
        in_ready_s = rst_n && !full_s && !bus.flush;
        push_s     = bus.in_valid && in_ready_s;
        pop_s      = valid_s && !bus.stall && !bus.flush;
    end

    // Next-state for pointers and occupancy; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = (PTR_W+1)'(0);
        end else begin
            if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            else        wr_ptr_d = wr_ptr_q;
            if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            else        rd_ptr_d = rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= (PTR_W+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pcp4_mem_q[wr_ptr_q] <= bus.in_pcp4;
            ins_mem_q[wr_ptr_q]  <= bus.in_ins;
        end
    end

    // Head entry, zeroed into a NOP bubble when the queue is empty.
    always_comb begin
        head_ins_s  = {DATA_W{1'b0}};
        head_pcp4_s = {DATA_W{1'b0}};
        if (valid_s) begin
            head_ins_s  = ins_mem_q[rd_ptr_q];
            head_pcp4_s = pcp4_mem_q[rd_ptr_q];
        end else begin
            head_ins_s  = {DATA_W{1'b0}};
            head_pcp4_s = {DATA_W{1'b0}};
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = valid_s;
    assign bus.out_pcp4  = head_pcp4_s;
    assign bus.out_ins   = head_ins_s;
    assign bus.op        = head_ins_s[31:26];
    assign bus.rs_fmt    = head_ins_s[25:21];
    assign bus.rt_ft     = head_ins_s[20:16];
    assign bus.rd_fs     = head_ins_s[15:11];
    assign bus.sh_fd     = head_ins_s[10:6];
    assign bus.fun       = head_ins_s[5:0];
    assign bus.im        = head_ins_s[15:0];
    assign bus.im_sext   = {{(DATA_W-16){head_ins_s[15]}}, head_ins_s[15:0]};
    assign bus.ad        = head_ins_s[25:0];
    assign bus.fmt       = classify(head_ins_s[31:26], head_ins_s[25:21]);
    assign bus.count     = count_q;
endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register in the modified MIPS core.
- Sits between fetch and decode. Buffers up to DEPTH fetched {pc+4, instruction} pairs in a FIFO.
- Presents the head entry to decode already split into R/I/J/FR/FI fields, with a format classification and a sign-extended immediate.
- Adds a valid/ready handshake, a decode-side stall and a branch flush; the single register had none of these.

Parameters:
- DATA_W, 32, width of pc+4 and of the instruction word.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.
- FP_OP, 6'b010001, opcode marking a floating-point (COP1) instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  queue accepts a word this cycle.
- in_pcp4  in  DATA_W  pc+4 of the fetched instruction.
- in_ins  in  DATA_W  fetched instruction.
- flush  in  1  discard all queued and incoming words.
- stall  in  1  decode cannot consume the head entry.
- out_valid  out  1  head entry is valid.
- out_pcp4  out  DATA_W  pc+4 of the head entry.
- out_ins  out  DATA_W  head instruction word.
- op  out  6  ins[31:26].
- rs_fmt  out  5  ins[25:21].
- rt_ft  out  5  ins[20:16].
- rd_fs  out  5  ins[15:11].
- sh_fd  out  5  ins[10:6].
- fun  out  6  ins[5:0].
- im  out  16  ins[15:0].
- im_sext  out  DATA_W  im sign-extended to DATA_W.
- ad  out  26  ins[25:0].
- fmt  out  3  format class: 0=R, 1=I, 2=J, 3=FR, 4=FI.
- count  out  PTR_W+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Pointers and count cleared to 0; out_valid=0.
  - out_pcp4=0 and out_ins=0, so every decoded field is 0 and fmt=0.
  - in_ready=0 while rst_n=0.
- Handshake rules:
  - in_ready = (count<DEPTH) && !flush.
  - Push when in_valid && in_ready.
  - Pop when out_valid && !stall && !flush.
  - No combinational path from in_* to out_*: a word pushed into an empty queue appears at the outputs the next cycle (latency 1).
- Outputs:
  - out_valid = (count!=0).
  - When out_valid=0, out_pcp4 and out_ins are forced to 0, so decode sees a NOP bubble.
  - Field outputs are combinational slices of out_ins.
- Format classification:
  - op==0 -> R.
  - op==2 or op==3 -> J.
  - op==FP_OP and rs_fmt in {16,17} -> FR.
  - op==FP_OP otherwise -> FI.
  - All other opcodes -> I.
- Count update:
  - Push only: +1. Pop only: -1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Full (count==DEPTH):
  - in_ready=0, even if a pop occurs in the same cycle; there is no full-queue passthrough.
  - The push is retried the next cycle.
- Empty:
  - A stall has no effect.
  - No pop occurs while out_valid=0.
- Flush (synchronous):
  - Next cycle count=0, pointers reset to 0, out_valid=0.
  - Any word offered in the flush cycle is dropped.
  - Flush has priority over stall, push and pop.
- Stall:
  - Head entry and all outputs are held stable.
  - Pushes continue while not full.
- Reset asserted mid-operation: immediate clear, independent of clk; all contents are lost.
- Storage array contents need no reset; only pointers and count are reset.

Test Plan:
- Reset, then push pcp4=4, ins=32'hA8221FF8 -> next cycle out_valid=1, op=6'b101010, rs_fmt=1, rt_ft=2, rd_fs=3, sh_fd=5'b11111, fun=6'b111000, fmt=I, count=1.
- Push ins=32'hA822FFFF with stall=1 held -> im=16'hFFFF, im_sext=32'hFFFFFFFF; outputs unchanged across 3 stalled cycles; after stall drops, pop and out_valid=0.
- Push DEPTH=4 words back-to-back with stall=1 -> count=4, in_ready=0; a 5th word is held off until one pop, then accepted; the pop order equals the push order across the pointer wrap.
- Classification: 32'h00221820 -> R; 32'h0AAAAAAA -> J with ad=26'h2AAAAAA; 32'h46020840 -> FR; 32'h45010003 -> FI.
- Queue holding 3 entries, flush=1 together with in_valid=1 -> next cycle count=0, out_valid=0, out_ins=0; the offered word is not stored.
- rst_n pulsed low between clock edges with 2 entries queued -> out_valid=0 and count=0 before the next edge; a subsequent push behaves as from empty.
